peatc_capture_sequencer: RTL and testbench
==========================================

Name: peatc_capture_sequencer

Overview:
Command-driven capture sequencer for the PEATC raw-signal path.
- Pops 32-bit commands from the host command FIFO (standard, non-FWFT read semantics).
- Selects a signal channel and sweeps a configurable address window of the raw-signal register bank.
- Pushes each DATA_W-bit sample into the host data FIFO, respecting backpressure.
- Generalises the fixed 67-address, 16-bit, no-backpressure sequencer: adds programmable start/length, read latency, settle time, abort and error reporting.

Parameters:
DATA_W, 16, sample width; also the width of the output FIFO data.
ADDR_W, 8, register-bank address width; must be ≤ 8.
CHAN_W, 8, channel-select width; must be ≤ 8.
DEFAULT_LEN, 67, sample count used when the command length field is 0; range 1..2^ADDR_W.
READ_LAT, 1, cycles from oAddr change to valid iSample; range 1..4.
SETTLE, 2, cycles oChanSel is held before the first address is issued; range 0..15.

Ports:
iClk  in  1  clock
iReset  in  1  synchronous, active-high reset
iCmdEmpty  in  1  command FIFO empty
oCmdRdEn  out  1  command FIFO read enable, one-cycle pulse
iCmdData  in  32  command word; valid the cycle after oCmdRdEn
iAbort  in  1  abort the current capture (level, sampled each cycle)
oChanSel  out  CHAN_W  channel select to the signal mux
oAddr  out  ADDR_W  register-bank address
iSample  in  DATA_W  register-bank read data
iOutFull  in  1  data FIFO full
oOutWrEn  out  1  data FIFO write enable
oOutData  out  DATA_W  data FIFO write data
oBusy  out  1  high in every state other than IDLE
oDone  out  1  one-cycle pulse at completion or abort
oErr  out  1  sticky error flag; cleared only by reset
oCount  out  ADDR_W+1  number of samples written in the current or last capture

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Command word fields:
  - [31:24] channel (truncated to CHAN_W).
  - [23:16] start address (truncated to ADDR_W).
  - [15:8] length; 0 selects DEFAULT_LEN.
  - [7:0] opcode: 0x01 = CAPTURE, 0x00 = NOP, any other value is illegal.
- States and transitions:
  - IDLE: if !iCmdEmpty, assert oCmdRdEn for exactly one cycle and go to LATCH.
  - LATCH: register iCmdData.
    - NOP: go to IDLE.
    - Illegal opcode: set oErr, pulse oDone, go to IDLE.
    - CAPTURE: drive oChanSel, load address = start, count = 0, go to SETTLE.
  - SETTLE: wait SETTLE cycles (0 means pass straight through), then go to ADDR.
  - ADDR: present oAddr, wait READ_LAT cycles, then go to WRITE.
  - WRITE:
    - If iOutFull: hold, with oOutWrEn = 0 and iSample re-sampled every cycle.
    - Else: oOutWrEn = 1 for one cycle, oOutData = iSample, count++, address++.
    - If count has reached the length, go to DONE; otherwise go back to ADDR.
  - DONE: pulse oDone for one cycle, go to IDLE. oChanSel holds its value until the next CAPTURE.
- Address wrap: the address increments modulo 2^ADDR_W; wrap is legal and is not an error.
- Throughput: one sample per READ_LAT+1 cycles when iOutFull is low.
- Abort:
  - iAbort high in SETTLE, ADDR or WRITE goes to DONE on the next cycle; no further writes occur.
  - If WRITE and iAbort coincide with !iOutFull, that final write still occurs.
  - iAbort is ignored in IDLE and LATCH.
- Queued commands: at most one command is popped per capture. Commands that arrive while busy stay in the FIFO.
- Reset mid-capture: returns to IDLE with all outputs 0. No partial write is issued in the reset cycle.
- Length arithmetic: length is ADDR_W+1 bits wide, so 256 is reachable via DEFAULT_LEN.

Decomposition:
- Shared package peatc_pkg holds:
  - Opcode constants OP_NOP and OP_CAPTURE.
  - Command field bit positions.
  - State encoding: IDLE, LATCH, SETTLE, ADDR, WRITE, DONE.
- One natural sub-module, peatc_wait_counter: a loadable down-counter with a zero flag, instanced for both SETTLE and READ_LAT.

Test Plan:
1. Defaults; command 0x03_00_00_01 → oChanSel = 3, oAddr sweeps 0..66, exactly 67 oOutWrEn pulses carrying iSample = address, then oDone pulse and oCount = 67.
2. Command 0x01_FE_04_01 → addresses FE, FF, 00, 01 (wrap), 4 writes, oErr = 0.
3. Length-8 capture with iOutFull forced high for 5 cycles during the 3rd WRITE → no write while full, exactly 8 writes total, no sample duplicated or dropped.
4. iAbort asserted after the 2nd write of a length-10 capture → at most 3 writes, oDone pulse, return to IDLE; the next queued command then pops normally.
5. Command 0x00_00_00_7F → oErr set, oDone pulse, no writes; a following valid CAPTURE executes while oErr stays 1.
6. iReset asserted in WRITE of a length-20 capture → the next cycle shows all outputs 0, no further oCmdRdEn until iReset deasserts and iCmdEmpty = 0.

Source files
------------

// File: rtl/peatc_pkg.sv
// ============================================================================
// Module   : peatc_pkg
// Purpose  : Shared opcodes, command field positions and FSM states for the
//            PEATC capture sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package peatc_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_CAPTURE = 8'h01;

  localparam int CMD_FIELD_W   = 8;
  localparam int CMD_CHAN_LSB  = 24;
  localparam int CMD_START_LSB = 16;
  localparam int CMD_LEN_LSB   = 8;
  localparam int CMD_OP_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ADDR   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } stateT;

endpackage

`default_nettype wire

// File: rtl/peatc_wait_counter.sv
// ============================================================================
// Module   : peatc_wait_counter
// Purpose  : Loadable down-counter that stops at zero and flags it.
// Revision : 1.0
// ============================================================================
`default_nettype none

module peatc_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iReset,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadVal,
  input  logic             iDec,
  output logic             oZero
);

  logic [WIDTH-1:0] rCount;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      rCount <= '0;
    end else if (iLoad) begin
      rCount <= iLoadVal;
    end else if (iDec && (rCount != '0)) begin
      rCount <= rCount - WIDTH'(1);
    end
  end

  assign oZero = (rCount == '0);

endmodule

`default_nettype wire

// File: rtl/peatc_capture_sequencer.sv
// ============================================================================
// Module   : peatc_capture_sequencer
// Purpose  : Pops capture commands, sweeps a register-bank window on the
//            selected channel and streams samples into the host data FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module peatc_capture_sequencer
  import peatc_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int CHAN_W      = 8,
  parameter int DEFAULT_LEN = 67,
  parameter int READ_LAT    = 1,
  parameter int SETTLE      = 2
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iCmdEmpty,
  output logic              oCmdRdEn,
  input  logic [31:0]       iCmdData,
  input  logic              iAbort,
  output logic [CHAN_W-1:0] oChanSel,
  output logic [ADDR_W-1:0] oAddr,
  input  logic [DATA_W-1:0] iSample,
  input  logic              iOutFull,
  output logic              oOutWrEn,
  output logic [DATA_W-1:0] oOutData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr,
  output logic [ADDR_W:0]   oCount
);

  localparam int LEN_W    = ADDR_W + 1;
  localparam int SETTLE_W = 4;
  localparam int LAT_W    = 2;

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD   = SETTLE_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [LAT_W-1:0]    LAT_LOAD      = LAT_W'(READ_LAT - 1);
  localparam logic [LEN_W-1:0]    DEFAULT_LEN_V = LEN_W'(DEFAULT_LEN);

  stateT             rState;
  logic [ADDR_W-1:0] rAddr;
  logic [LEN_W-1:0]  rLen;

  logic [7:0]        wOp;
  logic [7:0]        wLenField;
  logic [CHAN_W-1:0] wChan;
  logic [ADDR_W-1:0] wStart;
  logic [ADDR_W-1:0] wAddrInc;
  logic              wDecodeNow;
  logic              wIsCapture;
  logic              wLastWrite;
  logic              wToAddr;
  logic              wSettleZero;
  logic              wLatZero;

  assign wOp       = iCmdData[CMD_OP_LSB +: CMD_FIELD_W];
  assign wLenField = iCmdData[CMD_LEN_LSB +: CMD_FIELD_W];
  assign wChan     = iCmdData[CMD_CHAN_LSB +: CHAN_W];
  assign wStart    = iCmdData[CMD_START_LSB +: ADDR_W];
  assign wAddrInc  = rAddr + ADDR_W'(1);

  // The FIFO is non-FWFT: LATCH spends its first cycle with oCmdRdEn high,
  // and the command word is only valid on the second.
  assign wDecodeNow = (rState == ST_LATCH) && !oCmdRdEn;
  assign wIsCapture = wDecodeNow && (wOp == OP_CAPTURE);
  assign wLastWrite = ((oCount + LEN_W'(1)) == rLen);

  assign wToAddr = (wIsCapture && (SETTLE == 0))
                || ((rState == ST_SETTLE) && !iAbort && wSettleZero)
                || ((rState == ST_WRITE) && !iOutFull && !iAbort && !wLastWrite);

  peatc_wait_counter #(.WIDTH(SETTLE_W)) uSettleCnt (
    .iClk     (iClk),
    .iReset   (iReset),
    .iLoad    (wIsCapture),
    .iLoadVal (SETTLE_LOAD),
    .iDec     (rState == ST_SETTLE),
    .oZero    (wSettleZero)
  );

  peatc_wait_counter #(.WIDTH(LAT_W)) uLatCnt (
    .iClk     (iClk),
    .iReset   (iReset),
    .iLoad    (wToAddr),
    .iLoadVal (LAT_LOAD),
    .iDec     (rState == ST_ADDR),
    .oZero    (wLatZero)
  );

  assign oBusy = (rState != ST_IDLE);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      rState   <= ST_IDLE;
      rAddr    <= '0;
      rLen     <= '0;
      oCmdRdEn <= 1'b0;
      oChanSel <= '0;
      oAddr    <= '0;
      oOutWrEn <= 1'b0;
      oOutData <= '0;
      oDone    <= 1'b0;
      oErr     <= 1'b0;
      oCount   <= '0;
    end else begin
      oCmdRdEn <= 1'b0;
      oOutWrEn <= 1'b0;
      oDone    <= 1'b0;
      case (rState)
        ST_IDLE: begin
          if (!iCmdEmpty) begin
            oCmdRdEn <= 1'b1;
            rState   <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          if (wDecodeNow) begin
            if (wOp == OP_CAPTURE) begin
              oChanSel <= wChan;
              rAddr    <= wStart;
              oCount   <= '0;
              rLen     <= (wLenField == 8'd0) ? DEFAULT_LEN_V : LEN_W'(wLenField);
              if (SETTLE == 0) begin
                oAddr  <= wStart;
                rState <= ST_ADDR;
              end else begin
                rState <= ST_SETTLE;
              end
            end else if (wOp == OP_NOP) begin
              rState <= ST_IDLE;
            end else begin
              oErr   <= 1'b1;
              oDone  <= 1'b1;
              rState <= ST_IDLE;
            end
          end
        end
        ST_SETTLE: begin
          if (iAbort) begin
            rState <= ST_DONE;
          end else if (wSettleZero) begin
            oAddr  <= rAddr;
            rState <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (iAbort) begin
            rState <= ST_DONE;
          end else if (wLatZero) begin
            rState <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // A write decided in the same cycle as an abort still goes out.
          if (!iOutFull) begin
            oOutWrEn <= 1'b1;
            oOutData <= iSample;
            oCount   <= oCount + LEN_W'(1);
            rAddr    <= wAddrInc;
            if (iAbort || wLastWrite) begin
              rState <= ST_DONE;
            end else begin
              oAddr  <= wAddrInc;
              rState <= ST_ADDR;
            end
          end else if (iAbort) begin
            rState <= ST_DONE;
          end
        end
        ST_DONE: begin
          oDone  <= 1'b1;
          rState <= ST_IDLE;
        end
        default: begin
          rState <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_peatc_capture_sequencer.sv
// ============================================================================
// Module   : tb_peatc_capture_sequencer
// Purpose  : Command FIFO, register bank and data-FIFO scoreboard around the
//            capture sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_peatc_capture_sequencer;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 8;
  localparam int CHAN_W      = 8;
  localparam int DEFAULT_LEN = 67;
  localparam int READ_LAT    = 1;
  localparam int SETTLE      = 2;

  logic              iClk;
  logic              iReset;
  logic              iCmdEmpty;
  logic              oCmdRdEn;
  logic [31:0]       iCmdData;
  logic              iAbort;
  logic [CHAN_W-1:0] oChanSel;
  logic [ADDR_W-1:0] oAddr;
  logic [DATA_W-1:0] iSample;
  logic              iOutFull;
  logic              oOutWrEn;
  logic [DATA_W-1:0] oOutData;
  logic              oBusy;
  logic              oDone;
  logic              oErr;
  logic [ADDR_W:0]   oCount;

  peatc_capture_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CHAN_W(CHAN_W),
    .DEFAULT_LEN(DEFAULT_LEN), .READ_LAT(READ_LAT), .SETTLE(SETTLE)
  ) dut (
    .iClk(iClk), .iReset(iReset), .iCmdEmpty(iCmdEmpty), .oCmdRdEn(oCmdRdEn),
    .iCmdData(iCmdData), .iAbort(iAbort), .oChanSel(oChanSel), .oAddr(oAddr),
    .iSample(iSample), .iOutFull(iOutFull), .oOutWrEn(oOutWrEn), .oOutData(oOutData),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr), .oCount(oCount)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkEq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Environment and reference model state
  logic [15:0]  bank [0:255];
  logic [7:0]   addrHist [0:4];
  logic [7:0]   chanHist [0:4];
  logic [31:0]  cmdQ [$];
  logic [15:0]  expQ [$];
  logic [31:0]  holdCmd;
  bit           dataHold = 0;
  bit           prevRdEn = 0;
  bit           fullSeen = 0;
  bit           randFull = 0;
  bit           randAbort = 0;
  int           kind = 0;          // 0 none, 1 capture in flight, 2 illegal in flight
  int           capLen = 0;
  int           capWrites = 0;
  int           lastWr = -1;
  int           abortLimit = 0;
  bit           aborted = 0;
  logic [7:0]   expChan = 0;
  int           doneCnt = 0;
  int           cyc = 0;

  function automatic logic [15:0] sampleOf(input logic [7:0] a, input logic [7:0] ch);
    return bank[a] ^ {ch, 8'h00};
  endfunction

  task automatic pushCmd(input logic [31:0] c);
    cmdQ.push_back(c);
    iCmdEmpty = 1'b0;
  endtask

  task automatic modelPop(input logic [31:0] c);
    logic [7:0] op, ch, st, lf;
    op = c[7:0]; lf = c[15:8]; st = c[23:16]; ch = c[31:24];
    capWrites = 0;
    aborted   = 0;
    lastWr    = -1;
    expQ.delete();
    if (op == 8'h01) begin
      kind    = 1;
      expChan = ch;
      capLen  = (lf == 8'd0) ? DEFAULT_LEN : int'(lf);
      for (int i = 0; i < capLen; i++) expQ.push_back(sampleOf(8'(int'(st) + i), ch));
    end else if (op == 8'h00) begin
      kind = 0;
    end else begin
      kind = 2;
    end
  endtask

  // One clock cycle: observe outputs mid-cycle, update the model, drive inputs.
  task automatic tick();
    @(negedge iClk);
    cyc++;
    iCmdData = dataHold ? holdCmd : $urandom;
    dataHold = 0;
    fullSeen = fullSeen | iOutFull;

    if (oOutWrEn) begin
      checkEq("wr_not_full", {63'd0, iOutFull}, 64'd0);
      checkEq("wr_busy", {63'd0, oBusy}, 64'd1);
      if (expQ.size() == 0) begin
        checkEq("wr_expected", {63'd0, oOutWrEn}, 64'd0);
      end else begin
        checkEq("wdata", {48'd0, oOutData}, {48'd0, expQ.pop_front()});
        checkEq("wchan", {56'd0, oChanSel}, {56'd0, expChan});
        if (lastWr >= 0 && !fullSeen) checkEq("wr_gap", 64'(cyc - lastWr), 64'(READ_LAT + 1));
      end
      lastWr = cyc;
      capWrites++;
      fullSeen = 0;
    end

    if (oDone) begin
      doneCnt++;
      checkEq("done_expected", {63'd0, kind != 0}, 64'd1);
      if (kind == 1) begin
        checkEq("count", {55'd0, oCount}, 64'(capWrites));
        if (aborted) checkEq("abort_bound", {63'd0, capWrites <= abortLimit}, 64'd1);
        else         checkEq("nwrites", 64'(capWrites), 64'(capLen));
      end else if (kind == 2) begin
        checkEq("illegal_err", {63'd0, oErr}, 64'd1);
        checkEq("illegal_nowrite", 64'(capWrites), 64'd0);
      end
      expQ.delete();
      kind = 0;
    end

    if (oCmdRdEn) begin
      checkEq("rden_pulse", {63'd0, prevRdEn}, 64'd0);
      checkEq("pop_while_busy", 64'(kind), 64'd0);
      if (cmdQ.size() == 0) begin
        checkEq("pop_nonempty", {63'd0, oCmdRdEn}, 64'd0);
      end else begin
        holdCmd  = cmdQ.pop_front();
        dataHold = 1;
        modelPop(holdCmd);
      end
    end
    prevRdEn  = oCmdRdEn;
    iCmdEmpty = (cmdQ.size() == 0);

    if (iReset) begin
      expQ.delete();
      kind = 0; dataHold = 0; lastWr = -1; capWrites = 0; aborted = 0;
    end

    for (int i = 4; i > 0; i--) begin
      addrHist[i] = addrHist[i-1];
      chanHist[i] = chanHist[i-1];
    end
    addrHist[0] = oAddr;
    chanHist[0] = oChanSel;
    iSample = sampleOf(addrHist[READ_LAT], chanHist[READ_LAT]);

    if (randFull) iOutFull = ($urandom_range(0, 3) == 0);
    if (randAbort) begin
      iAbort = 1'b0;
      if (kind == 1 && $urandom_range(0, 63) == 0) begin
        iAbort = 1'b1;
        aborted = 1;
        abortLimit = capWrites + 1;
      end
    end
  endtask

  task automatic waitDone(input string tag, input int bound);
    int d0 = doneCnt;
    for (int i = 0; i < bound && doneCnt == d0; i++) tick();
    checkEq({tag, "_done"}, 64'(doneCnt - d0), 64'd1);
  endtask

  task automatic waitWrites(input string tag, input int n, input int bound);
    for (int i = 0; i < bound && capWrites < n; i++) tick();
    checkEq({tag, "_writes"}, {63'd0, capWrites >= n}, 64'd1);
  endtask

  function automatic logic [63:0] allOuts();
    return {17'd0, oCmdRdEn, oChanSel, oAddr, oOutWrEn, oOutData, oBusy, oDone, oErr, oCount};
  endfunction

  initial begin
    int expDone, d0;
    for (int i = 0; i < 256; i++) bank[i] = {8'($urandom), 8'(i)};
    for (int i = 0; i < 5; i++) begin addrHist[i] = 0; chanHist[i] = 0; end
    iReset = 1'b1; iCmdEmpty = 1'b1; iCmdData = '0; iAbort = 1'b0;
    iSample = '0; iOutFull = 1'b0;
    repeat (3) tick();
    checkEq("reset_outs", allOuts(), 64'd0);
    iReset = 1'b0;
    repeat (2) tick();

    // Default-length sweep
    pushCmd(32'h03_00_00_01);
    waitDone("t1", 1000);
    checkEq("t1_count", {55'd0, oCount}, 64'd67);
    checkEq("t1_chan", {56'd0, oChanSel}, 64'd3);
    checkEq("t1_idle", {63'd0, oBusy}, 64'd0);

    // Address wrap
    pushCmd(32'h01_FE_04_01);
    waitDone("t2", 200);
    checkEq("t2_count", {55'd0, oCount}, 64'd4);
    checkEq("t2_err", {63'd0, oErr}, 64'd0);

    // Backpressure during the third write
    pushCmd(32'h05_10_08_01);
    waitWrites("t3", 2, 200);
    iOutFull = 1'b1;
    repeat (5) tick();
    iOutFull = 1'b0;
    waitDone("t3", 200);
    checkEq("t3_count", {55'd0, oCount}, 64'd8);

    // Abort, then a queued command runs normally
    pushCmd(32'h07_20_0A_01);
    pushCmd(32'h02_30_03_01);
    waitWrites("t4", 2, 200);
    iAbort = 1'b1;
    aborted = 1;
    abortLimit = capWrites + 1;
    tick();
    iAbort = 1'b0;
    waitDone("t4a", 200);
    waitDone("t4b", 200);
    checkEq("t4_count", {55'd0, oCount}, 64'd3);
    checkEq("t4_chan", {56'd0, oChanSel}, 64'd2);

    // Illegal opcode: sticky error, later capture still works
    pushCmd(32'h00_00_00_7F);
    waitDone("t5a", 200);
    checkEq("t5_err", {63'd0, oErr}, 64'd1);
    pushCmd(32'h04_40_05_01);
    waitDone("t5b", 200);
    checkEq("t5_err_sticky", {63'd0, oErr}, 64'd1);
    checkEq("t5_count", {55'd0, oCount}, 64'd5);

    // Reset in the middle of a capture with a command waiting
    pushCmd(32'h09_50_14_01);
    waitWrites("t6", 5, 200);
    pushCmd(32'h0A_00_02_01);
    tick();
    iReset = 1'b1;
    tick();
    checkEq("t6_outs", allOuts(), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkEq("t6_rden", {63'd0, oCmdRdEn}, 64'd0);
    end
    iReset = 1'b0;
    waitDone("t6", 200);
    checkEq("t6_count", {55'd0, oCount}, 64'd2);

    // Random commands with random backpressure and occasional aborts
    expDone = 0;
    for (int n = 0; n < 15; n++) begin
      int r;
      logic [7:0] op;
      r = $urandom_range(0, 9);
      if (r < 7)       op = 8'h01;
      else if (r == 7) op = 8'h00;
      else             op = 8'($urandom_range(2, 255));
      if (op != 8'h00) expDone++;
      pushCmd({8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)), op});
    end
    d0 = doneCnt;
    randFull = 1;
    randAbort = 1;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (cmdQ.size() == 0 && kind == 0 && !oBusy && !dataHold && !oCmdRdEn) break;
    end
    randFull = 0;
    randAbort = 0;
    iOutFull = 1'b0;
    iAbort = 1'b0;
    repeat (4) tick();
    checkEq("rand_dones", 64'(doneCnt - d0), 64'(expDone));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
